fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 81 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Handshake bundle between fetch_unit, instruction memory, decoder and control.
// master = fetch unit side; slave = environment side.
interface fetch_unit_if #(
   parameter int unsigned PC_WIDTH = 8
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_ack;
   logic [7:0]          imem_rdata;
   logic                instr_valid;
   logic [7:0]          instr;
   logic [PC_WIDTH-1:0] instr_pc;
   logic                instr_ready;
   logic                redirect_valid;
   logic [PC_WIDTH-1:0] redirect_pc;
   logic                halt;
   logic                resume;
   logic                halted;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
      input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt, resume
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
      output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt, resume
   );
endinterface

// File: rtl/fetch_unit.sv
// Byte-wide instruction fetch unit: pc, one-entry output buffer, RUN/HALTED control.
// Redirect beats halt beats resume; ack is only honoured while a request is driven.
module fetch_unit #(
   parameter int unsigned         PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master fetch
);

   typedef enum logic {StRun, StHalted} state_e;

   state_e              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [7:0]          r_instr;
   logic [PC_WIDTH-1:0] r_instr_pc;
   logic                r_instr_valid;
   logic                r_halted;

   logic w_req;
   logic w_fire;
   logic w_take;

   // rst_n gates the request so nothing is issued while reset is held
   assign w_req  = rst_n && (r_state == StRun) && !fetch.redirect_valid && !fetch.halt &&
                   (!r_instr_valid || fetch.instr_ready);
   assign w_fire = w_req && fetch.imem_ack;
   assign w_take = r_instr_valid && fetch.instr_ready;

   assign fetch.imem_req    = w_req;
   assign fetch.imem_addr   = r_pc;
   assign fetch.instr_valid = r_instr_valid;
   assign fetch.instr       = r_instr;
   assign fetch.instr_pc    = r_instr_pc;
   assign fetch.halted      = r_halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StRun;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else if (fetch.redirect_valid) begin
         r_state       <= StRun;
         r_halted      <= 1'b0;
         r_pc          <= fetch.redirect_pc;
         r_instr_valid <= 1'b0;
      end else if (fetch.halt) begin
         r_state       <= StHalted;
         r_halted      <= 1'b1;
         r_instr_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StHalted: begin
               if (fetch.resume) begin
                  r_state  <= StRun;
                  r_halted <= 1'b0;
               end
            end
            StRun: begin
               if (w_fire) begin
                  r_instr       <= fetch.imem_rdata;
                  r_instr_pc    <= r_pc;
                  r_instr_valid <= 1'b1;
                  r_pc          <= r_pc + 1'b1;
               end else if (w_take) begin
                  r_instr_valid <= 1'b0;
               end
            end
            default: begin
               r_state  <= StRun;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

endmodule
